// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch/memory blocks.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Number of bits needed to index 'value' entries.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Assembles big-endian instructions from a UART byte stream and writes them to
// consecutive instruction-memory words from address 0 until the HALT word arrives.
module instruction_loader #(
  parameter int NB_INSTR           = 32,
  parameter int NB_REG             = 32,
  parameter int NB_BYTE            = 8,
  parameter int N_ADDR             = 2048,
  parameter int LOG2_N_INSMEM_ADDR = mips_pkg::clogb2(N_ADDR),
  parameter logic [NB_INSTR-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  output logic [NB_REG-1:0]             o_wr_addr,
  output logic [NB_INSTR-1:0]           o_wr_data,
  output logic                          o_wr_enable,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [LOG2_N_INSMEM_ADDR:0]   o_word_count
);
  import mips_pkg::*;

  localparam int NB_CNT = LOG2_N_INSMEM_ADDR + 1;
  localparam logic [NB_CNT-1:0] WORD_LIMIT = NB_CNT'(N_ADDR);
  localparam logic [NB_REG-1:0] ADDR_STEP  = NB_REG'(NB_INSTR / NB_BYTE);

  loader_state_t       state;
  loader_state_t       next_state;
  logic [1:0]          byte_cnt;
  logic [NB_INSTR-1:0] asm_word;
  logic [NB_INSTR-1:0] asm_next;
  logic [NB_CNT-1:0]   count_next;
  logic                accept;

  assign asm_next   = {asm_word[NB_INSTR-NB_BYTE-1:0], i_rx_data};
  assign count_next = o_word_count + NB_CNT'(1);
  assign o_busy     = (state == ST_LOAD) || (state == ST_WRITE);

  // A byte landing in WRITE already belongs to the next word if loading continues.
  assign accept = i_rx_valid &&
                  ((state == ST_LOAD) || ((state == ST_WRITE) && (next_state == ST_LOAD)));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_rx_valid && (byte_cnt == 2'd3)) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        // HALT wins even when it lands in the last memory slot.
        if (o_wr_data == HALT_WORD)         next_state = ST_DONE;
        else if (count_next == WORD_LIMIT)  next_state = ST_ERROR;
        else                                next_state = ST_LOAD;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt     <= '0;
      asm_word     <= '0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_wr_enable  <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_enable <= 1'b0;
      if (accept) begin
        asm_word <= asm_next;
        byte_cnt <= byte_cnt + 2'd1;
        if ((state == ST_LOAD) && (byte_cnt == 2'd3)) begin
          o_wr_data   <= asm_next;
          o_wr_enable <= 1'b1;
        end
      end
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            byte_cnt     <= '0;
            o_word_count <= '0;
            o_wr_addr    <= '0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
          end
        end
        ST_WRITE: begin
          o_word_count <= count_next;
          if (next_state == ST_LOAD) o_wr_addr <= o_wr_addr + ADDR_STEP;
          o_done  <= (next_state == ST_DONE);
          o_error <= (next_state == ST_ERROR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Drives one byte stream into a full-size loader and a 4-word loader and checks both.
module tb_instruction_loader;
  import mips_pkg::*;

  typedef logic [63:0] wr_t;
  localparam int NBIG   = 2048;
  localparam int NSMALL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic [31:0] wa0, wd0, wa1, wd1;
  logic        we0, busy0, done0, err0;
  logic        we1, busy1, done1, err1;
  logic [11:0] wc0;
  logic [2:0]  wc1;

  always #5 clk = ~clk;

  instruction_loader dut_big (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_wr_addr(wa0), .o_wr_data(wd0), .o_wr_enable(we0),
    .o_busy(busy0), .o_done(done0), .o_error(err0), .o_word_count(wc0)
  );

  instruction_loader #(.N_ADDR(NSMALL)) dut_small (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_wr_addr(wa1), .o_wr_data(wd1), .o_wr_enable(we1),
    .o_busy(busy1), .o_done(done1), .o_error(err1), .o_word_count(wc1)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] stim[$];
  wr_t        got0[$];
  wr_t        got1[$];
  wr_t        exp_q[$];

  always @(negedge clk) begin
    if (we0) got0.push_back({wa0, wd0});
    if (we1) got1.push_back({wa1, wd1});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the post-start byte stream grouped into words; loading stops at HALT or a full memory.
  task automatic model(input int n, output int cnt, output bit done, output bit err);
    logic [31:0] w;
    exp_q.delete();
    cnt = 0; done = 0; err = 0;
    for (int i = 0; i + 3 < stim.size() && !done && !err; i += 4) begin
      w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
      exp_q.push_back({32'(cnt * 4), w});
      cnt++;
      if (w == 32'hFFFF_FFFF) done = 1;
      else if (cnt == n)      err = 1;
    end
  endtask

  task automatic compare_dut(input int which, input string name);
    int cnt; bit d; bit e;
    wr_t g[$];
    logic [63:0] o_done, o_err, o_busy, o_wc;
    model((which == 0) ? NBIG : NSMALL, cnt, d, e);
    if (which == 0) begin
      g = got0; o_done = 64'(done0); o_err = 64'(err0); o_busy = 64'(busy0); o_wc = 64'(wc0);
    end else begin
      g = got1; o_done = 64'(done1); o_err = 64'(err1); o_busy = 64'(busy1); o_wc = 64'(wc1);
    end
    check({name, ".n_writes"}, 64'(g.size()), 64'(exp_q.size()));
    for (int i = 0; i < g.size() && i < exp_q.size(); i++)
      check($sformatf("%s.write%0d", name, i), g[i], exp_q[i]);
    check({name, ".done"}, o_done, 64'(d));
    check({name, ".error"}, o_err, 64'(e));
    check({name, ".busy"}, o_busy, 64'(!(d || e)));
    check({name, ".word_count"}, o_wc, 64'(cnt));
  endtask

  task automatic start_load();
    got0.delete(); got1.delete(); stim.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    stim.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], $urandom_range(0, maxgap));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h7FFF_FFFF;
    return w;
  endfunction

  task automatic finish_load(input string name);
    rx_valid = 1'b0;
    repeat (4) tick();
    compare_dut(0, {name, ".big"});
    compare_dut(1, {name, ".small"});
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".we"}, 64'({we0, we1}), 64'(0));
    check({name, ".busy"}, 64'({busy0, busy1}), 64'(0));
    check({name, ".done_err"}, 64'({done0, err0, done1, err1}), 64'(0));
    check({name, ".addr_big"}, 64'(wa0), 64'(0));
    check({name, ".data_big"}, 64'(wd0), 64'(0));
    check({name, ".wc"}, 64'({wc0, wc1}), 64'(0));
  endtask

  initial begin
    repeat (2) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Known program with write-latency probe
    start_load();
    send_word(32'h8C01_0004, 0);
    check("latency.we", 64'({we0, we1}), 64'(2'b11));
    check("latency.addr", 64'(wa0), 64'(0));
    check("latency.data", 64'(wd0), 64'(32'h8C01_0004));
    send_word(32'hFFFF_FFFF, 0);
    finish_load("prog1");

    // Back-to-back bytes, including one arriving during WRITE
    start_load();
    send_word(32'h0102_0304, 0);
    send_word(32'hAABB_CCDD, 0);
    send_word(32'hFFFF_FFFF, 0);
    finish_load("b2b");

    // Overflow on the small memory, then restart
    start_load();
    for (int i = 0; i < 5; i++) send_word(rand_word(), 2);
    send_word(32'hFFFF_FFFF, 1);
    finish_load("overflow");
    start_load();
    check("restart.error", 64'(err1), 64'(0));
    check("restart.busy", 64'(busy1), 64'(1));
    for (int i = 0; i < 3; i++) send_word(rand_word(), 2);
    send_word(32'hFFFF_FFFF, 2);
    finish_load("halt_last_slot");

    // Reset in the middle of a word
    start_load();
    send(8'h12, 0);
    send(8'h34, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midreset.no_strobe", 64'(got0.size() + got1.size()), 64'(0));
    start_load();
    send_word(32'h5566_7788, 1);
    send_word(32'hFFFF_FFFF, 1);
    finish_load("post_reset");

    // Bytes in DONE and IDLE are ignored; start during LOAD is ignored
    got0.delete(); got1.delete();
    for (int i = 0; i < 3; i++) send(8'($urandom), 1);
    repeat (3) tick();
    check("done_bytes.no_write", 64'(got0.size() + got1.size()), 64'(0));
    check("done_bytes.done", 64'({done0, done1, busy0}), 64'(3'b110));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    repeat (3) tick();
    check("idle_bytes.no_write", 64'(got0.size() + got1.size()), 64'(0));
    check("idle_bytes.busy", 64'({busy0, busy1, done0}), 64'(0));
    start_load();
    send(8'hDE, 0);
    send(8'hAD, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'hBE, 0);
    send(8'hEF, 1);
    send_word(32'hFFFF_FFFF, 0);
    finish_load("start_in_load");

    // Randomised programs of varying length
    for (int it = 0; it < 6; it++) begin
      int nw;
      nw = $urandom_range(1, 6);
      start_load();
      for (int i = 0; i < nw; i++) send_word(rand_word(), 2);
      send_word(32'hFFFF_FFFF, 2);
      finish_load($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction memory. Receives the program as a byte stream from the UART receiver, assembles big-endian 32-bit instructions, and writes them to consecutive word slots of instruction memory starting at byte address 0. Loading ends when the HALT word arrives. While loading is in progress, `o_busy` holds the fetch stage invalid. `o_done` releases the processor.

## Interface
- `NB_INSTR`, 32, instruction/data word width.
- `NB_REG`, 32, width of the write byte address (same as PC).
- `NB_BYTE`, 8, width of one received byte.
- `N_ADDR`, 2048, instruction memory depth in words.
- `LOG2_N_INSMEM_ADDR`, clogb2(N_ADDR), word index width.
- `HALT_WORD`, 32'hFFFF_FFFF, program terminator.

Ports:
- `i_clock`  in  1  single clock; all state changes on its rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  arm loading; sampled in IDLE/DONE/ERROR only.
- `i_rx_data`  in  NB_BYTE  received byte.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_wr_addr`  out  NB_REG  byte address of the write; always a multiple of 4.
- `o_wr_data`  out  NB_INSTR  assembled instruction.
- `o_wr_enable`  out  1  one-cycle write strobe to instruction memory.
- `o_busy`  out  1  high in LOAD and WRITE.
- `o_done`  out  1  level; HALT has been written.
- `o_error`  out  1  level; memory filled without HALT.
- `o_word_count`  out  LOG2_N_INSMEM_ADDR+1  number of words written in the current load.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: collecting bytes.
  - WRITE: one-cycle write.
  - DONE
  - ERROR
- IDLE, DONE, ERROR with `i_start`=1 → LOAD. On that edge: byte counter, word count and address clear to 0; `o_done` and `o_error` clear.
- LOAD:
  - Each `i_rx_valid` shifts a byte into the assembly register, MSB first: word = {b0, b1, b2, b3}.
  - The byte counter runs 0..3 and wraps to 0.
  - The edge that accepts the 4th byte moves to WRITE.
  - `i_start` is ignored in LOAD.
- WRITE, lasting exactly 1 cycle:
  - `o_wr_enable`=1, `o_wr_addr`=current address, `o_wr_data`=assembled word.
  - On the following edge, word count increments. Then:
    - word==HALT_WORD → DONE, taking priority over the overflow check.
    - else word count reaches N_ADDR → ERROR.
    - else address += 4 → LOAD.
- A byte with `i_rx_valid` during WRITE is accepted as byte 0 of the next word if the next state is LOAD; otherwise it is discarded.
- The HALT word is itself written to memory.
- Address arithmetic is NB_REG-wide unsigned. It never exceeds 4·(N_ADDR−1), so there is no wrap.
- Bytes arriving in IDLE, DONE or ERROR are discarded.

## Timing
- Reset values (asynchronous, immediate): state IDLE, all outputs 0, assembly register 0, counters 0.
- Write latency: `o_wr_enable` is high in the cycle after the cycle in which the 4th byte's `i_rx_valid` is high.
- `o_wr_addr` and `o_wr_data` are registered and stable for the whole strobe cycle.
- `o_done` and `o_error` rise in the cycle after the final WRITE cycle. They stay high until `i_start` or reset.
- `o_busy` rises the cycle after `i_start` is sampled. It falls in the same cycle that `o_done`/`o_error` rise.
- Minimum byte spacing: 1 cycle (back-to-back `i_rx_valid` is supported, including during WRITE).
- Reset asserted mid-word or mid-WRITE:
  - The partial word is lost.
  - No write strobe is emitted after reset.
  - The next load restarts at address 0.

## Structure
- Shared package `mips_pkg`:
  - loader state encoding (IDLE=0, LOAD=1, WRITE=2, DONE=3, ERROR=4; 3 bits)
  - HALT_WORD constant
  - clogb2 function, used for LOG2_N_INSMEM_ADDR across fetch and memory blocks.
- No sub-module. Byte assembly, counters and the FSM stay in one module.

## Test plan
- Reset then `i_start`, bytes 8C,01,00,04,FF,FF,FF,FF → writes (0, 32'h8C010004) then (4, 32'hFFFFFFFF); `o_done`=1; `o_word_count`=2; `o_busy`=0.
- Back-to-back bytes with a 5th byte during WRITE: 01,02,03,04,AA,BB,CC,DD, then HALT → writes 32'h01020304@0, 32'hAABBCCDD@4, HALT@8, with no byte lost.
- `N_ADDR`=4, five non-HALT words sent:
  - four writes at 0, 4, 8, C, then `o_error`=1.
  - the 5th word produces no write.
  - `i_start` → `o_error`=0; the next write goes to address 0.
- `N_ADDR`=4, 4th word = HALT → `o_done`=1 and `o_error`=0.
- Assert `i_reset` after 2 bytes of a word, then `i_start` and a full word + HALT → first write at address 0 containing only the post-reset bytes.
- `i_rx_valid` pulses in IDLE and DONE, plus `i_start` during LOAD → no writes, no state change, byte counter unaffected.
